// File: rtl/booth_divider_seq.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional build macro DIV_ERR_COUNT_EN adds a saturating error counter output err_count.
module booth_divider_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
`ifdef DIV_ERR_COUNT_EN
  ,output logic [7:0]    err_count
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(W);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [W-1:0]   ONE_W    = W'(1);
  localparam logic [2*W-1:0] ONE_2W   = (2*W)'(1);
  localparam logic [W-1:0]   Q_POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   Q_NEG_MAG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_quo;
  logic [W-1:0]    r_dsr;
  logic            r_sd;
  logic            r_sv;
  logic            r_ovf_pre;
  logic            r_dbz;
`ifdef DIV_ERR_COUNT_EN
  logic [7:0]      r_err_cnt;
`endif

  logic [2*W-1:0]  w_abs_dvd;
  logic [W-1:0]    w_abs_dsr;
  logic [W:0]      w_shift;
  logic [W:0]      w_sub;
  logic            w_ge;
  logic            w_qneg;
  logic [W-1:0]    w_q_lim;
  logic            w_ovf;
  logic [W-1:0]    w_q_signed;
  logic [W-1:0]    w_r_signed;
  logic [W-1:0]    w_q_sat;

  // Magnitudes are unsigned, so the most negative input maps to 2^(n-1) without loss.
  assign w_abs_dvd = dividend[2*W-1] ? (~dividend + ONE_2W) : dividend;
  assign w_abs_dsr = divisor[W-1]    ? (~divisor + ONE_W)   : divisor;

  // Restoring step: partial remainder stays below |divisor|, so W+1 bits suffice.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_sub   = w_shift - {1'b0, r_dsr};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});

  assign w_qneg     = r_sd ^ r_sv;
  assign w_q_lim    = w_qneg ? Q_NEG_MAG : Q_POS_MAX;
  assign w_ovf      = r_ovf_pre || (r_quo > w_q_lim);
  assign w_q_signed = w_qneg ? (~r_quo + ONE_W) : r_quo;
  assign w_r_signed = r_sd   ? (~r_rem + ONE_W) : r_rem;
  assign w_q_sat    = w_qneg ? Q_NEG_MAG : Q_POS_MAX;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr       <= '0;
      r_sd        <= 1'b0;
      r_sv        <= 1'b0;
      r_ovf_pre   <= 1'b0;
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef DIV_ERR_COUNT_EN
      r_err_cnt   <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_rem     <= w_abs_dvd[2*W-1:W];
            r_quo     <= w_abs_dvd[W-1:0];
            r_dsr     <= w_abs_dsr;
            r_sd      <= dividend[2*W-1];
            r_sv      <= divisor[W-1];
            // High half already >= divisor means the quotient cannot fit in W bits.
            r_ovf_pre <= (w_abs_dvd[2*W-1:W] >= w_abs_dsr);
            r_dbz     <= (divisor == '0);
            r_cnt     <= CNT_INIT;
            busy      <= 1'b1;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_sub[W-1:0] : w_shift[W-1:0];
          r_quo <= {r_quo[W-2:0], w_ge};
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
          if (r_dbz) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (w_ovf) begin
            quotient    <= w_q_sat;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= w_q_signed;
            remainder   <= w_r_signed;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
`ifdef DIV_ERR_COUNT_EN
          if ((r_dbz || w_ovf) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_ERR_COUNT_EN
  assign err_count = r_err_cnt;
`endif

endmodule

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Sequential signed divider: the inverse operation of the team's pipelined Booth multiplier.
- Divides a 2W-bit signed dividend (a product-width value) by a W-bit signed divisor, giving a W-bit signed quotient and a W-bit signed remainder.
- Iterative, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath so multiply results can be divided back down.

Parameters:
- W, 8, divisor/quotient/remainder width; dividend width is 2*W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- start  input  1  request; sampled only in IDLE.
- dividend  input  2W  signed two's-complement dividend, sampled with start.
- divisor  input  W  signed two's-complement divisor, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  W  signed quotient.
- remainder  output  W  signed remainder.
- div_by_zero  output  1  divisor was zero.
- overflow  output  1  quotient not representable in W signed bits.

Behaviour:
- Reset: rst low at any time, including mid-operation, immediately forces:
  - state IDLE;
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0;
  - iteration counter and internal registers cleared.
  - Operation resumes normally after rst is released.
- States:
  - IDLE: busy=0.
    - start=1 at an edge: latch |dividend| (2W-bit unsigned; -2^(2W-1) maps to 2^(2W-1)), |divisor|, and both sign bits.
    - Same edge: counter=W, state -> CALC, done -> 0.
  - CALC: busy=1.
    - Each edge performs one unsigned restoring shift-subtract step on the magnitudes and decrements the counter.
    - At the edge where the counter reaches 0, state -> FIX.
  - FIX: busy=1.
    - At the next edge: write quotient, remainder and flags; done=1 for exactly one cycle; state -> IDLE.
- Latency: constant W+1 edges from the start-sampling edge to done high (9 for W=8), for every case including error cases.
- Semantics: truncating division.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder takes the dividend's sign; |remainder| < |divisor|.
  - dividend = quotient*divisor + remainder when no error.
- Unsigned overflow pre-check at load: if (|dividend| >> W) >= |divisor|, the result is an overflow. CALC still runs, but its result is discarded.
- Signed overflow check in FIX:
  - positive result: unsigned quotient > 2^(W-1)-1 -> overflow;
  - negative result: unsigned quotient > 2^(W-1) -> overflow.
- On overflow: overflow=1; quotient saturates to 0x7F (positive) or 0x80 (negative) for W=8; remainder=0.
- divisor==0: div_by_zero=1, overflow=0, quotient=0, remainder=0. Takes priority over overflow.
- Flags and results are held until the next FIX write. They stay unchanged through IDLE and through the next operation's CALC.
- start while busy=1: ignored; latched operands are unaffected.
- start held high continuously: a new operation is accepted on the edge after done, i.e. on the first IDLE edge.

Optional Feature:
- Macro: DIV_ERR_COUNT_EN.
- When defined, adds output err_count[7:0]:
  - increments by 1 in the FIX write cycle whenever div_by_zero or overflow is set;
  - saturates at 255;
  - cleared by rst.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- dividend=16'd100, divisor=8'd7, start pulse -> done exactly 9 edges after the sampling edge; quotient=8'h0E, remainder=8'h02, flags 0; busy high for 9 cycles.
- dividend=16'hFF9C (-100), divisor=8'd7 -> quotient=8'hF2 (-14), remainder=8'hFE (-2), no flags.
- Negative-boundary case:
  - dividend=16'h4000 (16384), divisor=8'h80 (-128) -> quotient=8'h80, remainder=0, overflow=0.
  - dividend=16'hC000, divisor=8'h80 -> overflow=1, quotient=8'h7F, remainder=0.
  - dividend=16'h8000, divisor=8'h80 -> overflow=1, quotient=8'h7F.
- divisor=0, dividend=16'h1234 -> div_by_zero=1, overflow=0, quotient=0, remainder=0, still 9-edge latency; with DIV_ERR_COUNT_EN, err_count increments 0->1.
- Handshake:
  - second start with different operands pulsed mid-CALC -> ignored, first result correct;
  - start held high -> back-to-back operations, done pulses 10 edges apart.
- Reset mid-op: rst driven low 4 edges into CALC -> all outputs 0 immediately (asynchronously); after release, new start of 16'd100/8'd7 -> correct result after 9 edges.
